instruction_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit microcontroller datapath. It replaces the clock-delayer chain with single-clock enable strobes, so the PC, the instruction memory, the ALU/flag latch and the register-bank write port all run on one clock. It steps each instruction through fetch, decode, execute and writeback, and supports halt, free-run and (optional) single-step.

---
 rtl/instruction_sequencer.sv | 114 +++++++++++
 tb/tb_instruction_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer
// Brief   : Single-clock fetch/decode/execute/writeback enable sequencer.
//           Optional single-step support enabled by defining SINGLE_STEP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
  parameter int MEM_WAIT = 1
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_RUN,
  input  logic        i_STEP,
  input  logic        i_HALT,
  output logic        o_FETCH_EN,
  output logic        o_ALU_EN,
  output logic        o_WB_EN,
  output logic        o_PC_EN,
  output logic [2:0]  o_STATE,
  output logic        o_BUSY,
  output logic        o_HALTED,
  output logic [15:0] o_INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  localparam logic [3:0] c_WAIT_LAST = 4'(MEM_WAIT);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_nxt;
  logic        r_rst_seen;
  logic        w_start;
  logic [15:0] r_instr_cnt;

`ifdef SINGLE_STEP_EN
  logic r_step_q;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) r_step_q <= 1'b0;
    else        r_step_q <= i_STEP;
  end

  // Run takes priority; a step edge only matters when run is low.
  assign w_start = r_rst_seen & (i_RUN | (i_STEP & ~r_step_q));
`else
  logic w_unused_step;
  assign w_unused_step = i_STEP;
  assign w_start       = r_rst_seen & i_RUN;
`endif

  // Reset release is taken on the first edge, so IDLE can only be left on the second.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_rst_seen <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      r_rst_seen <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = 4'd0;
    case (r_state)
      S_IDLE:      if (w_start) w_next = S_FETCH;
      S_FETCH: begin
        if (r_wait_cnt == c_WAIT_LAST) begin
          w_next = S_DECODE;
        end else begin
          w_next     = S_FETCH;
          w_wait_nxt = r_wait_cnt + 4'd1;
        end
      end
      S_DECODE:    w_next = i_HALT ? S_HALTED : S_EXECUTE;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = i_RUN ? S_FETCH : S_IDLE;
      S_HALTED:    w_next = S_HALTED;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_instr_cnt <= 16'd0;
    end else if ((r_state == S_WRITEBACK) && (r_instr_cnt != 16'hFFFF)) begin
      r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  assign o_FETCH_EN  = (r_state == S_FETCH);
  assign o_ALU_EN    = (r_state == S_EXECUTE);
  assign o_WB_EN     = (r_state == S_WRITEBACK);
  assign o_PC_EN     = (r_state == S_WRITEBACK);
  assign o_BUSY      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
  assign o_HALTED    = (r_state == S_HALTED);
  assign o_STATE     = r_state;
  assign o_INSTR_CNT = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_sequencer
// Brief   : Self-checking bench; two sequencers (MEM_WAIT 1 and 3) share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic run   = 1'b0;
  logic step  = 1'b0;
  logic halt  = 1'b0;

  logic        fetch_en [2];
  logic        alu_en   [2];
  logic        wb_en    [2];
  logic        pc_en    [2];
  logic [2:0]  st       [2];
  logic        busy     [2];
  logic        halted   [2];
  logic [15:0] cnt      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(.MEM_WAIT(1)) dut1 (
    .i_CLK(clk), .i_RST(rst_n), .i_RUN(run), .i_STEP(step), .i_HALT(halt),
    .o_FETCH_EN(fetch_en[0]), .o_ALU_EN(alu_en[0]), .o_WB_EN(wb_en[0]),
    .o_PC_EN(pc_en[0]), .o_STATE(st[0]), .o_BUSY(busy[0]),
    .o_HALTED(halted[0]), .o_INSTR_CNT(cnt[0])
  );

  instruction_sequencer #(.MEM_WAIT(3)) dut3 (
    .i_CLK(clk), .i_RST(rst_n), .i_RUN(run), .i_STEP(step), .i_HALT(halt),
    .o_FETCH_EN(fetch_en[1]), .o_ALU_EN(alu_en[1]), .o_WB_EN(wb_en[1]),
    .o_PC_EN(pc_en[1]), .o_STATE(st[1]), .o_BUSY(busy[1]),
    .o_HALTED(halted[1]), .o_INSTR_CNT(cnt[1])
  );

`ifdef SINGLE_STEP_EN
  localparam int STEP_EN = 1;
`else
  localparam int STEP_EN = 0;
`endif

  // Reference model: each instruction is a run of mw+4 cycles; pos indexes into it.
  int mw [2] = '{1, 3};
  bit m_busy   [2];
  int m_pos    [2];
  bit m_halted [2];
  int m_cnt    [2];
  bit m_seen;
  bit m_stepq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_pos[k] = 0; m_halted[k] = 0; m_cnt[k] = 0;
      end
      m_seen  = 0;
      m_stepq = 0;
    end else begin
      bit launch_step;
      launch_step = (STEP_EN == 1) && step && !m_stepq;
      for (int k = 0; k < 2; k++) begin
        if (m_halted[k]) begin
          m_halted[k] = 1;
        end else if (!m_busy[k]) begin
          if (m_seen && (run || launch_step)) begin
            m_busy[k] = 1; m_pos[k] = 0;
          end
        end else if (m_pos[k] == mw[k] + 1 && halt) begin
          m_busy[k] = 0; m_halted[k] = 1;
        end else if (m_pos[k] == mw[k] + 3) begin
          if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
          if (run) m_pos[k] = 0;
          else     m_busy[k] = 0;
        end else begin
          m_pos[k] = m_pos[k] + 1;
        end
      end
      m_seen  = 1;
      m_stepq = step;
    end
  end

  function automatic logic [2:0] exp_state(input int k);
    if (m_halted[k])               return 3'd5;
    if (!m_busy[k])                return 3'd0;
    if (m_pos[k] <= mw[k])         return 3'd1;
    if (m_pos[k] == mw[k] + 1)     return 3'd2;
    if (m_pos[k] == mw[k] + 2)     return 3'd3;
    return 3'd4;
  endfunction

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s mw=%0d observed %0h expected %0h", tag, mw[k], obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [2:0] es;
      es = exp_state(k);
      chk("state",  k, 16'(st[k]),       16'(es));
      chk("fetch",  k, 16'(fetch_en[k]), 16'(es == 3'd1));
      chk("alu",    k, 16'(alu_en[k]),   16'(es == 3'd3));
      chk("wb",     k, 16'(wb_en[k]),    16'(es == 3'd4));
      chk("pc",     k, 16'(pc_en[k]),    16'(es == 3'd4));
      chk("busy",   k, 16'(busy[k]),     16'(es >= 3'd1 && es <= 3'd4));
      chk("halted", k, 16'(halted[k]),   16'(es == 3'd5));
      chk("count",  k, cnt[k],           16'(m_cnt[k]));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_state(input int k, input logic [2:0] s, input int bound);
    int i = 0;
    while (st[k] !== s && i < bound) begin
      cyc();
      i++;
    end
    chk("wait_state", k, 16'(st[k]), 16'(s));
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  initial begin
    int n;
    int i;

    // Reset held with run high and step toggling
    run = 1;
    for (int c = 0; c < 4; c++) begin
      step = c[0];
      cyc();
      chk("rst_state", 0, 16'(st[0]), 16'd0);
      chk("rst_fetch", 1, 16'(fetch_en[1]), 16'd0);
    end
    step = 0;

    // Free-run, MEM_WAIT=1: three PC pulses in 15 cycles from first FETCH
    rst_n = 1;
    wait_state(0, 3'd1, 6);
    n = int'(pc_en[0]);
    repeat (14) begin
      cyc();
      n += int'(pc_en[0]);
    end
    chk("pc_pulses_15", 0, 16'(n), 16'd3);
    cyc();
    chk("cnt_after_3", 0, cnt[0], 16'd3);

    // Run drop during EXECUTE completes the instruction then idles
    wait_state(0, 3'd3, 10);
    run = 0;
    cyc();
    chk("drop_wb", 0, 16'(wb_en[0]), 16'd1);
    chk("drop_pc", 0, 16'(pc_en[0]), 16'd1);
    cyc();
    chk("drop_busy", 0, 16'(busy[0]), 16'd0);
    repeat (8) cyc();

    // Halt on the second DECODE
    do_reset();
    run = 1;
    i = 0;
    while (cnt[0] !== 16'd1 && i < 20) begin
      cyc();
      i++;
    end
    chk("halt_wait_cnt", 0, cnt[0], 16'd1);
    halt = 1;
    for (int c = 0; c < 12; c++) begin
      run = c[1];
      cyc();
    end
    halt = 0;
    repeat (4) begin
      run = ~run;
      cyc();
    end
    chk("halt_state", 0, 16'(st[0]), 16'd5);
    chk("halt_cnt", 0, cnt[0], 16'd1);

    // Single-step: two launches plus one pulse while busy
    run = 0;
    do_reset();
    repeat (2) cyc();
    step = 1; cyc(); cyc();
    step = 0; cyc();
    step = 1; cyc();
    step = 0;
    repeat (20) cyc();
    step = 1; cyc(); cyc();
    step = 0;
    repeat (15) cyc();
    chk("step_cnt", 0, cnt[0], 16'(2 * STEP_EN));
    chk("step_cnt", 1, cnt[1], 16'(2 * STEP_EN));

    // Asynchronous reset in the middle of a MEM_WAIT=3 FETCH
    do_reset();
    run = 1;
    wait_state(1, 3'd1, 6);
    cyc();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_fetch", 1, 16'(fetch_en[1]), 16'd0);
    chk("async_state", 1, 16'(st[1]), 16'd0);
    chk("async_cnt", 1, cnt[1], 16'd0);
    cyc();
    rst_n = 1;
    repeat (20) cyc();

    // Randomized stimulus against the model
    for (int c = 0; c < 400; c++) begin
      run   = ($urandom % 5) != 0;
      step  = ($urandom % 3) == 0;
      halt  = ($urandom % 30) == 0;
      rst_n = ($urandom % 60) != 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
